dat_mem_dma: RTL and testbench

- Block-transfer engine and bus owner for the 256×8 data memory. It copies or fills up to 255 bytes with no processor involvement.
- Sits directly upstream of the data memory and drives its write-data, write-enable, address and immediate inputs.
- Passes processor load/store traffic straight through when idle and takes the memory port while a transfer runs.

---
 rtl/dat_mem_dma_if.sv | 36 +++
 rtl/dat_mem_dma.sv | 127 ++++++++++++
 tb/tb_dat_mem_dma.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dat_mem_dma_if.sv
// Bus bundle for dat_mem_dma: transfer control, processor store port and data-memory port.
// slave is the engine's view; master is the surrounding system's view.
interface dat_mem_dma_if;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic [7:0] cksum;
  logic [7:0] cpu_dat_in;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_immed;
  logic       cpu_wr_en;
  logic [7:0] mem_dat_out;
  logic [7:0] mem_dat_in;
  logic [7:0] mem_addr;
  logic [7:0] mem_immed;
  logic       mem_wr_en;

  modport slave (
    input  start, mode, src, dst, len, fill_val,
    input  cpu_dat_in, cpu_addr, cpu_immed, cpu_wr_en, mem_dat_out,
    output busy, done, cksum,
    output mem_dat_in, mem_addr, mem_immed, mem_wr_en
  );

  modport master (
    output start, mode, src, dst, len, fill_val,
    output cpu_dat_in, cpu_addr, cpu_immed, cpu_wr_en, mem_dat_out,
    input  busy, done, cksum,
    input  mem_dat_in, mem_addr, mem_immed, mem_wr_en
  );
endinterface

// File: rtl/dat_mem_dma.sv
// Copy/fill DMA engine owning the 256x8 data-memory port; processor traffic passes through when idle.
// Optional write checksum enabled by defining DAT_MEM_DMA_CKSUM_EN.
module dat_mem_dma (
  input  logic          clk,
  input  logic          rst_n,
  dat_mem_dma_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] dst_q, dst_d;
  logic [7:0] len_q, len_d;
  logic [7:0] fill_q, fill_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;
  logic       last;

  // Copy vs fill is carried by the state itself, so mode needs no holding register.
  assign last = (idx_q == len_q - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    fill_d        = fill_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_dat_in = bus.cpu_dat_in;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_immed = bus.cpu_immed;
    bus.mem_wr_en = bus.cpu_wr_en;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d  = bus.src;
          dst_d  = bus.dst;
          len_d  = bus.len;
          fill_d = bus.fill_val;
          idx_d  = '0;
          if (bus.len == 8'd0)  state_d = DONE;
          else if (bus.mode)    state_d = FILL;
          else                  state_d = RD;
        end
      end
      RD: begin
        bus.busy       = 1'b1;
        bus.mem_addr   = src_q + idx_q;
        bus.mem_immed  = '0;
        bus.mem_dat_in = buf_q;
        bus.mem_wr_en  = 1'b0;
        buf_d          = bus.mem_dat_out;
        state_d        = WR;
      end
      WR: begin
        bus.busy       = 1'b1;
        bus.mem_addr   = dst_q + idx_q;
        bus.mem_immed  = '0;
        bus.mem_dat_in = buf_q;
        bus.mem_wr_en  = 1'b1;
        idx_d          = idx_q + 8'd1;
        state_d        = last ? DONE : RD;
      end
      FILL: begin
        bus.busy       = 1'b1;
        bus.mem_addr   = dst_q + idx_q;
        bus.mem_immed  = '0;
        bus.mem_dat_in = fill_q;
        bus.mem_wr_en  = 1'b1;
        idx_d          = idx_q + 8'd1;
        state_d        = last ? DONE : FILL;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DAT_MEM_DMA_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == IDLE && bus.start)
      cksum_d = '0;
    else if (state_q == WR || state_q == FILL)
      cksum_d = cksum_q + bus.mem_dat_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end

  assign bus.cksum = cksum_q;
`else
  assign bus.cksum = '0;
`endif

endmodule

// File: tb/tb_dat_mem_dma.sv
// Self-checking bench for dat_mem_dma: table vectors from the test plan, hand-written corner
// sequences and randomized transfers checked against a byte-array reference model.
module tb_dat_mem_dma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dat_mem_dma_if bus ();

  dat_mem_dma dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_dat = '0;

  assign bus.mem_dat_out = mem[8'(bus.mem_addr + bus.mem_immed)];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (bus.mem_wr_en) mem[8'(bus.mem_addr + bus.mem_immed)] <= bus.mem_dat_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    n_checks++;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== exp_mem[a]) begin
        if (bad < 4)
          $display("FAIL %s: mem[0x%02h] got 0x%02h, expected 0x%02h", name, a, mem[a], exp_mem[a]);
        bad++;
      end
    end
    if (bad != 0) n_fail++;
  endtask

  task automatic pre_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    exp_mem[a] = d;
  endtask

  // Reference: forward byte-by-byte copy or fill with 8-bit address wrap; returns the byte sum.
  task automatic model_xfer(input logic m, input logic [7:0] s, d, l, fv, output logic [7:0] ck);
    logic [7:0] v;
    ck = '0;
    for (int i = 0; i < int'(l); i++) begin
      v = m ? fv : exp_mem[8'(int'(s) + i)];
      exp_mem[8'(int'(d) + i)] = v;
      ck = ck + v;
    end
  endtask

  task automatic run_xfer(input string tag, input logic m, input logic [7:0] s, d, l, fv,
                          input int exp_busy, input logic [7:0] exp_ck,
                          input bit poke_start, input bit poke_cpu);
    int busy_cnt = 0, done_at = 0, bmis = 0;
    logic [7:0] ck_done = 8'hxx;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = fv;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= exp_busy + 2; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.busy !== 1'(c <= exp_busy)) bmis++;
      if (bus.done === 1'b1 && done_at == 0) done_at = c;
      if (c == exp_busy + 1) ck_done = bus.cksum;
      if (poke_start && c == 2) begin
        bus.start = 1'b1; bus.mode = ~m; bus.src = 8'hC3; bus.dst = 8'hD0;
        bus.len = 8'd1; bus.fill_val = 8'h99;
      end
      if (poke_start && c == 3) bus.start = 1'b0;
      if (poke_cpu) begin
        bus.cpu_wr_en = 1'(c < exp_busy);
        bus.cpu_addr = 8'h80; bus.cpu_immed = 8'h00; bus.cpu_dat_in = 8'hEE;
      end
    end
    bus.cpu_wr_en = 1'b0;
    bus.cpu_immed = 8'h33;
    chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, " busy_pattern_errs"}, bmis, 0);
    chk({tag, " done_cycle"}, done_at, exp_busy + 1);
`ifdef DAT_MEM_DMA_CKSUM_EN
    chk({tag, " cksum"}, ck_done, exp_ck);
`else
    chk({tag, " cksum"}, ck_done, 8'h00);
`endif
    chk_mem({tag, " mem"});
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] src, dst, len, fv;
    int         exp_busy;
    logic [7:0] exp_ck;
    bit         poke_start, poke_cpu;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] ck;
    logic       rm;
    logic [7:0] rs, rd, rl, rf;

    vecs[0] = '{1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 4, 8'h94, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 6, 8'h06, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 3, 8'h0E, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 8'h50, 8'd0, 8'h11, 0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h30, 8'h31, 8'd3, 8'h00, 6, 8'h65, 1'b0, 1'b1};

    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
    bus.cpu_dat_in = 8'h6B; bus.cpu_addr = 8'h5C; bus.cpu_immed = 8'h33; bus.cpu_wr_en = 1'b0;

    #2;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset cksum", bus.cksum, 8'h00);
    chk("reset mem_addr passthru", bus.mem_addr, 8'h5C);
    chk("reset mem_dat_in passthru", bus.mem_dat_in, 8'h6B);
    chk("reset mem_immed passthru", bus.mem_immed, 8'h33);

    for (int a = 0; a < 256; a++) pre_write(8'(a), 8'($urandom));
    pre_write(8'h20, 8'h01);
    pre_write(8'h21, 8'h02);
    pre_write(8'h22, 8'h03);
    pre_write(8'h30, 8'h77);
    @(negedge clk) rst_n = 1'b1;
    chk_mem("preload");

    for (int i = 0; i < 5; i++) begin
      model_xfer(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fv, ck);
      run_xfer($sformatf("vec%0d", i), vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len,
               vecs[i].fv, vecs[i].exp_busy, vecs[i].exp_ck, vecs[i].poke_start, vecs[i].poke_cpu);
    end

    // Idle processor store lands, with address formed from addr + immed.
    @(negedge clk);
    bus.cpu_wr_en = 1'b1; bus.cpu_addr = 8'h7F; bus.cpu_immed = 8'h01; bus.cpu_dat_in = 8'hEE;
    @(posedge clk);
    #1 bus.cpu_wr_en = 1'b0; bus.cpu_immed = 8'h33;
    exp_mem[8'h80] = 8'hEE;
    chk_mem("idle cpu write");

    // Reset after two writes of an 8-byte fill.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1; bus.dst = 8'h60; bus.len = 8'd8; bus.fill_val = 8'h3C;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", bus.busy, 1'b0);
    chk("midreset done", bus.done, 1'b0);
    chk("midreset mem_wr_en", bus.mem_wr_en, 1'b0);
    chk("midreset cksum", bus.cksum, 8'h00);
    exp_mem[8'h60] = 8'h3C;
    exp_mem[8'h61] = 8'h3C;
    chk_mem("midreset mem");
    @(negedge clk) rst_n = 1'b1;
    model_xfer(1'b1, 8'h00, 8'h60, 8'd8, 8'h3C, ck);
    run_xfer("after_reset", 1'b1, 8'h00, 8'h60, 8'd8, 8'h3C, 8, 8'hE0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 8'($urandom);
      rd = 8'($urandom);
      rl = 8'($urandom_range(0, 12));
      rf = 8'($urandom);
      model_xfer(rm, rs, rd, rl, rf, ck);
      run_xfer($sformatf("rand%0d", i), rm, rs, rd, rl, rf,
               (rl == 0) ? 0 : (rm ? int'(rl) : 2 * int'(rl)), ck, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
